// File: rtl/crforth_pkg.sv
// rtl/crforth_pkg.sv - shared fetch/issue state encoding and next-PC select constants
package crforth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;

    localparam logic [1:0] SEL_PC   = 2'b00;
    localparam logic [1:0] SEL_OP1  = 2'b01;
    localparam logic [1:0] SEL_OP2  = 2'b10;
    localparam logic [1:0] SEL_HALT = 2'b11;

    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/issue sequencer with PC, SSR and fetch timeout
module fetch_sequencer
    import crforth_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          WAIT_LIMIT = 8
) (
    input  logic        i_CLK,
    input  logic        i_RSTN,
    output logic [15:0] o_IMEM_ADDR,
    output logic        o_IMEM_REQ,
    input  logic        i_IMEM_ACK,
    input  logic [15:0] i_IMEM_DATA,
    output logic [15:0] o_INSTRUCTION,
    output logic        o_INSTR_VALID,
    input  logic        i_EXEC_DONE,
    input  logic [1:0]  i_MUXJUMPADDR,
    input  logic [1:0]  i_SETSSR,
    input  logic [15:0] i_OP1,
    input  logic [15:0] i_OP2,
    input  logic        i_RESUME,
    output logic [15:0] o_PC,
    output logic        o_SSR,
    output logic        o_HALTED,
    output logic        o_FAULT
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  instr_q, instr_d;
    logic         ssr_q, ssr_d;
    logic [7:0]   wait_q, wait_d;
    logic         fault_q, fault_d;
    logic [15:0]  next_pc;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            ssr_q   <= 1'b0;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ssr_q   <= ssr_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // Conditional branch takes OP2 only when the top of stack is zero.
    always_comb begin
        next_pc = pc_inc(pc_q);
        case (i_MUXJUMPADDR)
            SEL_PC:  next_pc = pc_inc(pc_q);
            SEL_OP1: next_pc = i_OP1;
            SEL_OP2: next_pc = (i_OP1 == 16'h0000) ? i_OP2 : pc_inc(pc_q);
            default: next_pc = pc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ssr_d   = ssr_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                wait_d  = 8'd0;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // Ack wins over a coinciding timeout.
                if (i_IMEM_ACK) begin
                    instr_d = i_IMEM_DATA;
                    wait_d  = 8'd0;
                    state_d = ST_ISSUE;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    wait_d  = 8'd0;
                    state_d = ST_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_ISSUE: begin
                if (i_EXEC_DONE) begin
                    pc_d = next_pc;
                    if (!i_SETSSR[1]) begin
                        ssr_d = i_SETSSR[0];
                    end
                    state_d = (i_MUXJUMPADDR == SEL_HALT) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                if (i_RESUME) begin
                    pc_d    = pc_inc(pc_q);
                    fault_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_IMEM_ADDR   = pc_q;
    assign o_PC          = pc_q;
    assign o_IMEM_REQ    = (state_q == ST_FETCH);
    assign o_INSTR_VALID = (state_q == ST_ISSUE);
    assign o_HALTED      = (state_q == ST_HALT);
    assign o_INSTRUCTION = instr_q;
    assign o_SSR         = ssr_q;
    assign o_FAULT       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        exec_done;
    logic [1:0]  muxjumpaddr;
    logic [1:0]  setssr;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        resume;
    logic [15:0] pc;
    logic        ssr;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_sequencer #(
        .RESET_PC   (16'h0000),
        .WAIT_LIMIT (8)
    ) dut (
        .i_CLK         (clk),
        .i_RSTN        (rst_n),
        .o_IMEM_ADDR   (imem_addr),
        .o_IMEM_REQ    (imem_req),
        .i_IMEM_ACK    (imem_ack),
        .i_IMEM_DATA   (imem_data),
        .o_INSTRUCTION (instruction),
        .o_INSTR_VALID (instr_valid),
        .i_EXEC_DONE   (exec_done),
        .i_MUXJUMPADDR (muxjumpaddr),
        .i_SETSSR      (setssr),
        .i_OP1         (op1),
        .i_OP2         (op2),
        .i_RESUME      (resume),
        .o_PC          (pc),
        .o_SSR         (ssr),
        .o_HALTED      (halted),
        .o_FAULT       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_now(input logic [15:0] data);
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack  = 1'b0;
    endtask

    task automatic finish_issue(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] ss);
        exec_done   = 1'b1;
        muxjumpaddr = sel;
        op1         = a;
        op2         = b;
        setssr      = ss;
        tick();
        exec_done   = 1'b0;
        setssr      = 2'b10;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000; exec_done = 1'b0;
        muxjumpaddr = 2'b00; setssr = 2'b10; op1 = 16'h0000; op2 = 16'h0000; resume = 1'b0;

        #12;
        check("rst_pc",    pc,          16'h0000);
        check("rst_req",   {15'd0, imem_req},    16'd0);
        check("rst_valid", {15'd0, instr_valid}, 16'd0);
        check("rst_instr", instruction, 16'h0000);
        check("rst_halt",  {15'd0, halted},      16'd0);
        check("rst_fault", {15'd0, fault},       16'd0);
        check("rst_ssr",   {15'd0, ssr},         16'd0);

        @(posedge clk); #1 rst_n = 1'b1;
        check("idle_req", {15'd0, imem_req}, 16'd0);
        tick();
        check("fetch1_req",  {15'd0, imem_req}, 16'd1);
        check("fetch1_addr", imem_addr, 16'h0000);
        tick();
        ack_now(16'h8107);
        check("issue_instr", instruction, 16'h8107);
        check("issue_valid", {15'd0, instr_valid}, 16'd1);
        check("issue_pc",    pc, 16'h0000);
        check("issue_req",   {15'd0, imem_req}, 16'd0);

        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("issue_hold_valid", {15'd0, instr_valid}, 16'd1);
        check("issue_hold_instr", instruction, 16'h8107);
        check("resume_ign_halt",  {15'd0, halted}, 16'd0);

        finish_issue(2'b01, 16'h0040, 16'h0000, 2'b01);
        check("jmp_op1_addr", imem_addr, 16'h0040);
        check("jmp_op1_req",  {15'd0, imem_req}, 16'd1);
        check("ssr_load1",    {15'd0, ssr}, 16'd1);

        ack_now(16'h1111);
        finish_issue(2'b10, 16'h0000, 16'h0123, 2'b10);
        check("bz_taken", imem_addr, 16'h0123);
        check("ssr_hold", {15'd0, ssr}, 16'd1);

        ack_now(16'h2222);
        finish_issue(2'b10, 16'h0005, 16'h0999, 2'b00);
        check("bz_not_taken", imem_addr, 16'h0124);
        check("ssr_load0",    {15'd0, ssr}, 16'd0);

        exec_done = 1'b1; muxjumpaddr = 2'b01; op1 = 16'h7777;
        tick();
        exec_done = 1'b0;
        check("done_ign_fetch", imem_addr, 16'h0124);
        ack_now(16'h3333);
        finish_issue(2'b01, 16'hFFFF, 16'h0000, 2'b10);
        check("pc_ffff", imem_addr, 16'hFFFF);
        ack_now(16'h4444);
        finish_issue(2'b00, 16'h0000, 16'h0000, 2'b10);
        check("pc_wrap", imem_addr, 16'h0000);

        for (int i = 0; i < 7; i++) tick();
        check("to_7_req",   {15'd0, imem_req}, 16'd1);
        check("to_7_fault", {15'd0, fault}, 16'd0);
        tick();
        check("to_8_fault",  {15'd0, fault},  16'd1);
        check("to_8_halted", {15'd0, halted}, 16'd1);
        check("to_8_req",    {15'd0, imem_req}, 16'd0);
        check("to_8_valid",  {15'd0, instr_valid}, 16'd0);

        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_fault", {15'd0, fault}, 16'd0);
        check("resume_addr",  imem_addr, 16'h0001);
        check("resume_req",   {15'd0, imem_req}, 16'd1);

        for (int i = 0; i < 7; i++) tick();
        ack_now(16'h5A5A);
        check("ack8_fault", {15'd0, fault}, 16'd0);
        check("ack8_valid", {15'd0, instr_valid}, 16'd1);
        check("ack8_instr", instruction, 16'h5A5A);

        finish_issue(2'b01, 16'h0010, 16'h0000, 2'b10);
        ack_now(16'h6666);
        finish_issue(2'b11, 16'h0000, 16'h0000, 2'b01);
        check("halt_sel_halted", {15'd0, halted}, 16'd1);
        check("halt_sel_pc",     pc, 16'h0010);
        check("halt_sel_fault",  {15'd0, fault}, 16'd0);
        check("halt_sel_ssr",    {15'd0, ssr}, 16'd1);
        tick();
        check("halt_stays", {15'd0, halted}, 16'd1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("halt_resume_addr", imem_addr, 16'h0011);
        check("halt_resume_req",  {15'd0, imem_req}, 16'd1);

        ack_now(16'h9ABC);
        check("pre_rst_valid", {15'd0, instr_valid}, 16'd1);
        #2 rst_n = 1'b0;
        imem_ack = 1'b1;
        #1;
        check("async_valid", {15'd0, instr_valid}, 16'd0);
        check("async_instr", instruction, 16'h0000);
        check("async_pc",    pc, 16'h0000);
        check("async_ssr",   {15'd0, ssr}, 16'd0);
        check("async_req",   {15'd0, imem_req}, 16'd0);
        check("async_halt",  {15'd0, halted}, 16'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        check("late_ack_req",   {15'd0, imem_req}, 16'd1);
        check("late_ack_valid", {15'd0, instr_valid}, 16'd0);
        check("late_ack_addr",  imem_addr, 16'h0000);
        imem_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter WAIT_LIMIT, default 8, meaning the maximum cycles spent in FETCH awaiting acknowledge before faulting; legal range 2..255.
REQ-003 SHALL have port i_CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_RSTN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port o_IMEM_ADDR  output  16  instruction-memory address, equal to the PC.
REQ-006 SHALL have port o_IMEM_REQ  output  1  fetch request.
REQ-007 SHALL have port i_IMEM_ACK  input  1  fetch acknowledge; i_IMEM_DATA is valid in the same cycle.
REQ-008 SHALL have port i_IMEM_DATA  input  16  fetched instruction word.
REQ-009 SHALL have port o_INSTRUCTION  output  16  registered instruction presented to the control unit.
REQ-010 SHALL have port o_INSTR_VALID  output  1  o_INSTRUCTION valid; datapath controls are derived from it.
REQ-011 SHALL have port i_EXEC_DONE  input  1  datapath has completed the presented instruction.
REQ-012 SHALL have port i_MUXJUMPADDR  input  2  next-PC select: 00 PC+1, 01 OP1, 10 OP2 if OP1==0 else PC+1, 11 halt.
REQ-013 SHALL have port i_SETSSR  input  2  10 = hold SSR; 00/01 = load bit 0 into SSR.
REQ-014 SHALL have port i_OP1  input  16  top of stack.
REQ-015 SHALL have port i_OP2  input  16  second of stack.
REQ-016 SHALL have port i_RESUME  input  1  leave HALT.
REQ-017 SHALL have port o_PC  output  16  current program counter.
REQ-018 SHALL have port o_SSR  output  1  status/mode register.
REQ-019 SHALL have port o_HALTED  output  1  high in HALT state.
REQ-020 SHALL have port o_FAULT  output  1  fetch timeout occurred; sticky until resume.

Function
REQ-021 SHALL implement the four states IDLE, FETCH, ISSUE and HALT; IDLE transitions to FETCH unconditionally after one cycle.
REQ-022 SHALL, in FETCH, drive o_IMEM_REQ=1 and o_IMEM_ADDR=PC; on i_IMEM_ACK it SHALL register i_IMEM_DATA into o_INSTRUCTION, clear the wait counter and enter ISSUE in the next cycle.
REQ-023 SHALL increment the wait counter in each FETCH cycle without ack; when the counter reaches WAIT_LIMIT-1 without ack it SHALL set o_FAULT and enter HALT.
REQ-024 SHALL give ack priority when ack and the timeout coincide; no fault is raised.
REQ-025 SHALL, in ISSUE, hold o_INSTR_VALID=1 with o_INSTRUCTION stable until i_EXEC_DONE is high.
REQ-026 SHALL, on i_EXEC_DONE in ISSUE, update PC per i_MUXJUMPADDR and SSR per i_SETSSR in that edge, then go to FETCH, or go to HALT if the select is 11 (PC unchanged).
REQ-027 SHALL compute PC+1 modulo 2^16, so that FFFF wraps to 0000.
REQ-028 SHALL ignore i_EXEC_DONE outside ISSUE and i_IMEM_ACK outside FETCH.
REQ-029 SHALL, in HALT, hold o_HALTED=1 and o_IMEM_REQ=0; on i_RESUME it SHALL set PC to PC+1, clear o_FAULT and enter FETCH; i_RESUME SHALL be ignored in other states.
REQ-030 SHALL hold o_IMEM_REQ=0 and o_INSTR_VALID=0 in IDLE and HALT; latency from ack to o_INSTR_VALID SHALL be 1 cycle.

Reset
REQ-031 SHALL, on i_RSTN low, act immediately: state=IDLE, PC=RESET_PC, o_INSTRUCTION=16'h0000, SSR=0, wait counter=0, o_FAULT=0, and o_IMEM_REQ, o_INSTR_VALID and o_HALTED all 0.
REQ-032 SHALL abandon any in-flight fetch or issue on reset mid-operation; a late ack SHALL be ignored.

Structure
REQ-033 SHALL take the state encoding and the next-PC select constants (PC/OP1/OP2/HALT = 00/01/10/11) from shared package crforth_pkg, common with the control unit.
REQ-034 SHALL be a single module with no sub-module; the next-PC mux SHALL be inline combinational logic.

Verification
REQ-035 SHALL cover: reset, then ack on 2nd FETCH cycle with data 16'h8107 -> o_INSTRUCTION=16'h8107 and o_INSTR_VALID=1 in the following cycle, o_PC=0000.
REQ-036 SHALL cover: ISSUE with EXEC_DONE, select 01, OP1=16'h0040 -> next o_IMEM_ADDR=0040; select 10, OP1=0, OP2=16'h0123 -> 0123; select 10, OP1=5 -> PC+1.
REQ-037 SHALL cover: PC=FFFF, select 00 -> next fetch at 0000.
REQ-038 SHALL cover: no ack for WAIT_LIMIT=8 -> o_FAULT=1 and o_HALTED=1 after the 8th FETCH cycle; ack in the 8th cycle -> no fault.
REQ-039 SHALL cover: select 11 at PC=0010 -> HALT, then i_RESUME -> fault cleared and fetch at 0011; i_SETSSR=01 -> o_SSR=1, i_SETSSR=10 -> o_SSR held.
REQ-040 SHALL cover: i_RSTN asserted during ISSUE -> all outputs at reset values immediately, first fetch at RESET_PC.
